pru_cmd_scheduler: RTL and testbench

PRU_CMD_SCHEDULER -- requirements
Module: pru_cmd_scheduler

---
 rtl/pru_sched_pkg.sv | 37 +++
 rtl/rr_arbiter2.sv | 42 ++++
 rtl/pru_cmd_scheduler.sv | 149 ++++++++++++++
 tb/tb_pru_cmd_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pru_sched_pkg.sv
// Shared definitions for the PRU command scheduler: FSM states, beat address
// offsets and the command word field layout understood by the PRU preprocessor.
package pru_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        GAP   = 2'd3
    } sched_state_e;

    localparam logic [7:0] BEAT0_OFS = 8'h00;
    localparam logic [7:0] BEAT1_OFS = 8'h04;

    // Word 0 layout
    localparam int ROW_LSB    = 0;
    localparam int ROW_W      = 9;
    localparam int COL_LSB    = 9;
    localparam int COL_W      = 10;
    localparam int COLOR_LSB  = 19;
    localparam int COLOR_W    = 2;
    localparam int SHAPE_LSB  = 21;
    localparam int SHAPE_W    = 2;

    // Word 1 layout
    localparam int HR_LSB     = 0;
    localparam int HR_W       = 9;
    localparam int WIDTH_LSB  = 9;
    localparam int WIDTH_W    = 10;
    localparam int SUB_BIT    = 19;
    localparam int CLOAD_BIT  = 20;

    function automatic logic [31:0] beat_addr(input logic [23:0] base, input logic [7:0] ofs);
        return {base, ofs};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. The pointer names the requester examined first;
// ptr_nxt hands priority to the other side after a grant.
module rr_arbiter2 (
    input  logic       advance,
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       ptr_nxt
);

    logic [1:0] pick_s;

    // Priority decode on {pointer, request vector}
    always_comb begin
        pick_s = 2'b00;
        case ({ptr, req})
            3'b0_01, 3'b0_11, 3'b1_01: pick_s = 2'b01;
            3'b0_10, 3'b1_10, 3'b1_11: pick_s = 2'b10;
            default:                   pick_s = 2'b00;
        endcase
    end

    // Gate the pick with the advance strobe and derive the next pointer
    always_comb begin
        grant   = 2'b00;
        ptr_nxt = ptr;
        if (advance) begin
            grant = pick_s;
            if (pick_s[0]) begin
                ptr_nxt = 1'b1;
            end else if (pick_s[1]) begin
                ptr_nxt = 1'b0;
            end else begin
                ptr_nxt = ptr;
            end
        end else begin
            grant   = 2'b00;
            ptr_nxt = ptr;
        end
    end

endmodule

// File: rtl/pru_cmd_scheduler.sv
// Arbitrates CPU and overlay-engine draw commands and issues each as two
// acknowledged bus beats into the PRU preprocessor write window.
module pru_cmd_scheduler
    import pru_sched_pkg::*;
#(
    parameter logic [23:0] PRU_BASE   = 24'h400001,
    parameter int          GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [1:0][31:0] req_word0,
    input  logic [1:0][31:0] req_word1,
    output logic [1:0]       req_grant,
    output logic [1:0]       req_done,
    output logic             write,
    output logic [31:0]      bus_addr,
    output logic [31:0]      data,
    input  logic             ack,
    input  logic             busy,
    output logic             active,
    output logic [15:0]      cmd_count
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_e       state_r;
    logic               rr_ptr_r;
    logic               winner_r;
    logic [31:0]        word1_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [1:0]         req_grant_r;
    logic [1:0]         req_done_r;
    logic               write_r;
    logic [31:0]        bus_addr_r;
    logic [31:0]        data_r;
    logic               active_r;
    logic [15:0]        cmd_count_r;

    logic               advance_s;
    logic [1:0]         pick_s;
    logic               ptr_nxt_s;
    logic               ack_ok_s;

    // Arbitration is only offered while idle and the rasteriser is free
    always_comb begin
        advance_s = 1'b0;
        if ((state_r == IDLE) && !busy) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
    end

    // A floating ack compares unknown here and is therefore treated as wait
    assign ack_ok_s = (ack == 1'b1);

    rr_arbiter2 u_arb (
        .advance (advance_s),
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .grant   (pick_s),
        .ptr_nxt (ptr_nxt_s)
    );

    // Command FSM with all bus and handshake outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            rr_ptr_r    <= 1'b0;
            winner_r    <= 1'b0;
            word1_r     <= 32'h0000_0000;
            gap_cnt_r   <= '0;
            req_grant_r <= 2'b00;
            req_done_r  <= 2'b00;
            write_r     <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            data_r      <= 32'h0000_0000;
            active_r    <= 1'b0;
            cmd_count_r <= 16'h0000;
        end else begin
            req_grant_r <= 2'b00;
            req_done_r  <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (pick_s != 2'b00) begin
                        state_r     <= BEAT0;
                        rr_ptr_r    <= ptr_nxt_s;
                        winner_r    <= pick_s[1];
                        req_grant_r <= pick_s;
                        word1_r     <= req_word1[pick_s[1]];
                        data_r      <= req_word0[pick_s[1]];
                        bus_addr_r  <= beat_addr(PRU_BASE, BEAT0_OFS);
                        write_r     <= 1'b1;
                        active_r    <= 1'b1;
                    end
                end
                BEAT0: begin
                    if (ack_ok_s) begin
                        state_r    <= BEAT1;
                        bus_addr_r <= beat_addr(PRU_BASE, BEAT1_OFS);
                        data_r     <= word1_r;
                    end
                end
                BEAT1: begin
                    if (ack_ok_s) begin
                        req_done_r  <= winner_r ? 2'b10 : 2'b01;
                        cmd_count_r <= cmd_count_r + 16'h0001;
                        write_r     <= 1'b0;
                        bus_addr_r  <= 32'h0000_0000;
                        data_r      <= 32'h0000_0000;
                        if (GAP_CYCLES == 0) begin
                            state_r  <= IDLE;
                            active_r <= 1'b0;
                        end else begin
                            state_r   <= GAP;
                            gap_cnt_r <= GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_r == '0) begin
                        state_r  <= IDLE;
                        active_r <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    write_r    <= 1'b0;
                    bus_addr_r <= 32'h0000_0000;
                    data_r     <= 32'h0000_0000;
                    active_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_grant = req_grant_r;
    assign req_done  = req_done_r;
    assign write     = write_r;
    assign bus_addr  = bus_addr_r;
    assign data      = data_r;
    assign active    = active_r;
    assign cmd_count = cmd_count_r;

endmodule

// File: tb/tb_pru_cmd_scheduler.sv
// Directed self-checking bench for pru_cmd_scheduler (default parameters).
module tb_pru_cmd_scheduler;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_word0;
    logic [1:0][31:0] req_word1;
    logic [1:0]       req_grant;
    logic [1:0]       req_done;
    logic             write;
    logic [31:0]      bus_addr;
    logic [31:0]      data;
    logic             ack;
    logic             busy;
    logic             active;
    logic [15:0]      cmd_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A0 = 32'h4000_0100;
    localparam logic [31:0] A1 = 32'h4000_0104;

    pru_cmd_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_word0 (req_word0),
        .req_word1 (req_word1),
        .req_grant (req_grant),
        .req_done  (req_done),
        .write     (write),
        .bus_addr  (bus_addr),
        .data      (data),
        .ack       (ack),
        .busy      (busy),
        .active    (active),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (active !== 1'b0 && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL wait_idle active=%b want 0 after %0d cycles", active, n); end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 2'b00; busy = 1'b0; ack = 1'b1;
        req_word0 = '0; req_word1 = '0;
        @(posedge clk); #1;
        checks++; if (write !== 1'b0)          begin errors++; $display("FAIL rst_write got %b want 0", write); end
        checks++; if (req_grant !== 2'b00)     begin errors++; $display("FAIL rst_grant got %b want 00", req_grant); end
        checks++; if (req_done !== 2'b00)      begin errors++; $display("FAIL rst_done got %b want 00", req_done); end
        checks++; if (active !== 1'b0)         begin errors++; $display("FAIL rst_active got %b want 0", active); end
        checks++; if (bus_addr !== 32'h0)      begin errors++; $display("FAIL rst_addr got %h want 0", bus_addr); end
        checks++; if (data !== 32'h0)          begin errors++; $display("FAIL rst_data got %h want 0", data); end
        checks++; if (cmd_count !== 16'h0)     begin errors++; $display("FAIL rst_count got %h want 0", cmd_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single;
        req_word0[0] = 32'h0012_3456; req_word1[0] = 32'h0008_1010;
        req_valid = 2'b01; ack = 1'b1;
        tick;
        checks++; if (req_grant !== 2'b01)      begin errors++; $display("FAIL single_grant got %b want 01", req_grant); end
        checks++; if (write !== 1'b1)           begin errors++; $display("FAIL single_w0 got %b want 1", write); end
        checks++; if (bus_addr !== A0)          begin errors++; $display("FAIL single_a0 got %h want %h", bus_addr, A0); end
        checks++; if (data !== 32'h0012_3456)   begin errors++; $display("FAIL single_d0 got %h want 00123456", data); end
        checks++; if (active !== 1'b1)          begin errors++; $display("FAIL single_active got %b want 1", active); end
        req_valid = 2'b00; req_word0[0] = 32'hDEAD_BEEF; req_word1[0] = 32'hCAFE_F00D;
        tick;
        checks++; if (req_grant !== 2'b00)      begin errors++; $display("FAIL single_grant_pulse got %b want 00", req_grant); end
        checks++; if (bus_addr !== A1)          begin errors++; $display("FAIL single_a1 got %h want %h", bus_addr, A1); end
        checks++; if (data !== 32'h0008_1010)   begin errors++; $display("FAIL single_d1 got %h want 00081010", data); end
        checks++; if (req_done !== 2'b00)       begin errors++; $display("FAIL single_early_done got %b want 00", req_done); end
        tick;
        checks++; if (req_done !== 2'b01)       begin errors++; $display("FAIL single_done got %b want 01", req_done); end
        checks++; if (cmd_count !== 16'd1)      begin errors++; $display("FAIL single_count got %0d want 1", cmd_count); end
        checks++; if (write !== 1'b0)           begin errors++; $display("FAIL single_gap_write got %b want 0", write); end
        checks++; if (bus_addr !== 32'h0)       begin errors++; $display("FAIL single_gap_addr got %h want 0", bus_addr); end
        tick;
        checks++; if (req_done !== 2'b00)       begin errors++; $display("FAIL single_done_pulse got %b want 00", req_done); end
        checks++; if (active !== 1'b1)          begin errors++; $display("FAIL single_gap2_active got %b want 1", active); end
        tick;
        checks++; if (active !== 1'b0)          begin errors++; $display("FAIL single_idle got %b want 0", active); end
    endtask

    task automatic test_ack_stall;
        req_word0[0] = 32'h1111_0001; req_word1[0] = 32'h2222_0002;
        ack = 1'bz; req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) ack = 1'b1;
            checks++;
            if (write !== 1'b1 || bus_addr !== A0 || data !== 32'h1111_0001) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got w=%b a=%h d=%h want 1/%h/11110001", i, write, bus_addr, data, A0);
            end
            tick;
        end
        checks++; if (bus_addr !== A1 || data !== 32'h2222_0002) begin errors++; $display("FAIL stall_beat1 got a=%h d=%h want %h/22220002", bus_addr, data, A1); end
        wait_idle;
        checks++; if (cmd_count !== 16'd2)      begin errors++; $display("FAIL stall_count got %0d want 2", cmd_count); end
    endtask

    task automatic test_busy;
        req_word0[1] = 32'h3333_0003; req_word1[1] = 32'h4444_0004;
        busy = 1'b1; req_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++; if (req_grant !== 2'b00 || active !== 1'b0) begin errors++; $display("FAIL busy_hold cycle %0d got g=%b act=%b want 00/0", i, req_grant, active); end
        end
        busy = 1'b0;
        tick;
        checks++; if (req_grant !== 2'b10)      begin errors++; $display("FAIL busy_release_grant got %b want 10", req_grant); end
        checks++; if (data !== 32'h3333_0003)   begin errors++; $display("FAIL busy_data got %h want 33330003", data); end
        req_valid = 2'b00;
        wait_idle;
        checks++; if (cmd_count !== 16'd3)      begin errors++; $display("FAIL busy_count got %0d want 3", cmd_count); end
    endtask

    task automatic test_contention;
        logic [1:0] exp_g;
        logic [1:0] exp_d;
        logic       exp_a;
        apply_reset;
        ack = 1'b1; req_valid = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            tick;
            exp_g = 2'b00; exp_d = 2'b00; exp_a = (k % 5 != 0);
            if (k % 5 == 1) exp_g = ((k / 5) % 2 == 0) ? 2'b01 : 2'b10;
            if (k % 5 == 3) exp_d = ((k / 5) % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (req_grant !== exp_g) begin errors++; $display("FAIL cont_grant k=%0d got %b want %b", k, req_grant, exp_g); end
            checks++; if (req_done !== exp_d)  begin errors++; $display("FAIL cont_done k=%0d got %b want %b", k, req_done, exp_d); end
            checks++; if (active !== exp_a)    begin errors++; $display("FAIL cont_active k=%0d got %b want %b", k, active, exp_a); end
        end
        req_valid = 2'b00;
        wait_idle;
        checks++; if (cmd_count !== 16'd4)      begin errors++; $display("FAIL cont_count got %0d want 4", cmd_count); end
    endtask

    task automatic test_reset_beat1;
        req_valid = 2'b01; ack = 1'b1;
        tick;
        req_valid = 2'b00;
        tick;
        checks++; if (write !== 1'b1 || bus_addr !== A1) begin errors++; $display("FAIL rb1_setup got w=%b a=%h want 1/%h", write, bus_addr, A1); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (write !== 1'b0)           begin errors++; $display("FAIL rb1_write got %b want 0", write); end
        checks++; if (active !== 1'b0)          begin errors++; $display("FAIL rb1_active got %b want 0", active); end
        checks++; if (bus_addr !== 32'h0 || data !== 32'h0) begin errors++; $display("FAIL rb1_bus got a=%h d=%h want 0/0", bus_addr, data); end
        checks++; if (cmd_count !== 16'h0)      begin errors++; $display("FAIL rb1_count got %0d want 0", cmd_count); end
        @(posedge clk); #1;
        checks++; if (req_done !== 2'b00)       begin errors++; $display("FAIL rb1_done got %b want 00", req_done); end
        req_valid = 2'b11;
        rst = 1'b0;
        #1;
        checks++; if (req_grant !== 2'b00)      begin errors++; $display("FAIL rb1_early_grant got %b want 00", req_grant); end
        tick;
        checks++; if (req_grant !== 2'b01)      begin errors++; $display("FAIL rb1_ptr got %b want 01", req_grant); end
        req_valid = 2'b00;
        wait_idle;
        checks++; if (cmd_count !== 16'd1)      begin errors++; $display("FAIL rb1_after_count got %0d want 1", cmd_count); end
    endtask

    task automatic test_wrap;
        force dut.cmd_count_r = 16'hFFFF;
        #1;
        release dut.cmd_count_r;
        #1;
        checks++; if (cmd_count !== 16'hFFFF)   begin errors++; $display("FAIL wrap_preload got %h want FFFF", cmd_count); end
        req_valid = 2'b10; ack = 1'b1;
        tick;
        req_valid = 2'b00;
        tick;
        tick;
        checks++; if (req_done !== 2'b10)       begin errors++; $display("FAIL wrap_done got %b want 10", req_done); end
        checks++; if (cmd_count !== 16'h0000)   begin errors++; $display("FAIL wrap_count got %h want 0000", cmd_count); end
        wait_idle;
    endtask

    initial begin
        test_reset;
        test_single;
        test_ack_stall;
        test_busy;
        test_contention;
        test_reset_beat1;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
